// File: rtl/line_sequencer.sv
// rtl/line_sequencer.sv - command FIFO and launch sequencer for the line drawer
// Buffers line commands, resolves polyline chaining and launches one line at a time.
module line_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 2048
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_stax,
    input  logic [9:0]  cmd_stay,
    input  logic [9:0]  cmd_endx,
    input  logic [9:0]  cmd_endy,
    input  logic        cmd_chain,
    output logic        ld_go,
    input  logic        ld_busy,
    output logic [9:0]  ld_stax,
    output logic [9:0]  ld_stay,
    output logic [9:0]  ld_endx,
    output logic [9:0]  ld_endy,
    output logic [15:0] lines_done,
    output logic        err_timeout,
    output logic        idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 41;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_ARM   = 2'd2;
    localparam logic [1:0] S_DRAW  = 2'd3;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          empty, full, push, pop;
    logic [EW-1:0] head;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0]   done_q, done_d;
    logic          err_q, err_d;
    logic [9:0]    stax_q, stay_q, endx_q, endy_q;
    logic [9:0]    last_x_q, last_y_q;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign cnt_inc   = (cnt_q == WD_LIMIT) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !ld_busy) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_ARM;
            end
            S_ARM: begin
                cnt_d = cnt_inc;
                if (ld_busy) begin
                    state_d = S_DRAW;
                end else if (cnt_inc == WD_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d = cnt_inc;
                if (!ld_busy) begin
                    done_d = done_q + 16'd1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_inc == WD_LIMIT) begin
                    // drawer cannot be aborted: flag it and keep waiting
                    err_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_chain, cmd_stax, cmd_stay, cmd_endx, cmd_endy};
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            stax_q   <= '0;
            stay_q   <= '0;
            endx_q   <= '0;
            endy_q   <= '0;
            last_x_q <= '0;
            last_y_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
                endx_q   <= head[19:10];
                endy_q   <= head[9:0];
                last_x_q <= head[19:10];
                last_y_q <= head[9:0];
                stax_q   <= head[40] ? last_x_q : head[39:30];
                stay_q   <= head[40] ? last_y_q : head[29:20];
            end
        end
    end

    assign ld_go       = (state_q == S_ISSUE) && !rst;
    assign ld_stax     = stax_q;
    assign ld_stay     = stay_q;
    assign ld_endx     = endx_q;
    assign ld_endy     = endy_q;
    assign lines_done  = done_q;
    assign err_timeout = err_q;
    assign idle        = (state_q == S_IDLE) && empty && !ld_busy;
endmodule

// File: tb/tb_line_sequencer.sv
// tb/tb_line_sequencer.sv - scoreboard bench for line_sequencer with a drawer stub
module tb_line_sequencer;
    logic        pclk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_stax, cmd_stay, cmd_endx, cmd_endy;
    logic        cmd_chain;
    logic        ld_go;
    logic        stub_busy;
    logic [9:0]  ld_stax, ld_stay, ld_endx, ld_endy;
    logic [15:0] lines_done;
    logic        err_timeout;
    logic        idle;

    int n_vec = 0;
    int n_err = 0;

    logic [39:0] exp_q[$];
    logic [9:0]  m_last_x, m_last_y;

    int stub_len  = 2;
    bit rand_len  = 0;
    int skip_gos  = 0;
    int epoch     = 0;
    int exp_done  = 0;

    line_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
        .pclk(pclk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_stax(cmd_stax), .cmd_stay(cmd_stay),
        .cmd_endx(cmd_endx), .cmd_endy(cmd_endy), .cmd_chain(cmd_chain),
        .ld_go(ld_go), .ld_busy(stub_busy),
        .ld_stax(ld_stax), .ld_stay(ld_stay), .ld_endx(ld_endx), .ld_endy(ld_endy),
        .lines_done(lines_done), .err_timeout(err_timeout), .idle(idle)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Drawer stub: a go seen in a cycle raises busy after the next edge for stub_len cycles
    initial begin
        int  cnt = 0;
        int  tag = 0;
        logic g;
        stub_busy = 1'b0;
        forever begin
            @(negedge pclk);
            g = ld_go;
            @(posedge pclk);
            #1;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    stub_busy = 1'b0;
                    if (tag == epoch) exp_done++;
                end
            end else if (g === 1'b1) begin
                if (skip_gos > 0) begin
                    skip_gos--;
                end else begin
                    stub_busy = 1'b1;
                    cnt = rand_len ? int'($urandom_range(1, 4)) : stub_len;
                    tag = epoch;
                end
            end
        end
    end

    // Monitor: every launch is matched against the next expected segment
    initial begin
        logic        go_prev = 1'b0;
        logic        active  = 1'b0;
        logic [39:0] cur = '0;
        logic [39:0] e;
        forever begin
            @(negedge pclk);
            if (rst) begin
                active  = 1'b0;
                go_prev = 1'b0;
            end else begin
                if (ld_go) begin
                    chk("go_single_pulse", 64'(go_prev), 64'(0));
                    chk("go_while_busy", 64'(stub_busy), 64'(0));
                    if (exp_q.size() == 0) begin
                        bound_fail("unexpected_go");
                    end else begin
                        e = exp_q.pop_front();
                        chk("launch_coords", 64'({ld_stax, ld_stay, ld_endx, ld_endy}), 64'(e));
                    end
                    cur    = {ld_stax, ld_stay, ld_endx, ld_endy};
                    active = 1'b1;
                end else if (active && stub_busy) begin
                    chk("coord_stable", 64'({ld_stax, ld_stay, ld_endx, ld_endy}), 64'(cur));
                end
                go_prev = ld_go;
            end
        end
    end

    task automatic push(input logic [9:0] sx, input logic [9:0] sy,
                        input logic [9:0] ex, input logic [9:0] ey, input logic ch);
        int n = 0;
        @(negedge pclk);
        cmd_valid = 1'b1;
        cmd_stax = sx; cmd_stay = sy; cmd_endx = ex; cmd_endy = ey; cmd_chain = ch;
        while (!cmd_ready && n < 400) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) begin
            bound_fail("push_accept");
            cmd_valid = 1'b0;
        end else begin
            @(posedge pclk);
            if (ch) exp_q.push_back({m_last_x, m_last_y, ex, ey});
            else    exp_q.push_back({sx, sy, ex, ey});
            m_last_x = ex;
            m_last_y = ey;
        end
    endtask

    task automatic end_push();
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge pclk);
        #2;
        rst = 1'b1;
        cmd_valid = 1'b0;
        exp_q.delete();
        m_last_x = '0;
        m_last_y = '0;
        epoch++;
        exp_done = 0;
        @(posedge pclk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge pclk);
        while (!(idle && exp_q.size() == 0 && !stub_busy) && n < budget) begin
            @(negedge pclk);
            n++;
        end
        if (n >= budget) bound_fail(name);
    endtask

    task automatic wait_busy(input string name, input logic lvl, input int budget);
        int n = 0;
        while (stub_busy !== lvl && n < budget) begin
            @(negedge pclk);
            n++;
        end
        if (n >= budget) bound_fail(name);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_stax = '0; cmd_stay = '0; cmd_endx = '0; cmd_endy = '0; cmd_chain = 1'b0;
        m_last_x = '0;
        m_last_y = '0;
        repeat (3) @(posedge pclk);
        #2;
        rst = 1'b0;

        @(negedge pclk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("rst_ld_go", 64'(ld_go), 64'(0));
        chk("rst_coords", 64'({ld_stax, ld_stay, ld_endx, ld_endy}), 64'(0));
        chk("rst_lines_done", 64'(lines_done), 64'(0));
        chk("rst_err", 64'(err_timeout), 64'(0));
        chk("rst_idle", 64'(idle), 64'(1));

        // single line, launch latency
        stub_len = 4;
        push(10'd0, 10'd0, 10'd3, 10'd0, 1'b0);
        end_push();
        chk("t1_go_early", 64'(ld_go), 64'(0));
        @(negedge pclk);
        chk("t1_go_latency", 64'(ld_go), 64'(1));
        wait_idle("t1_idle", 200);
        chk("t1_lines_done", 64'(lines_done), 64'(1));
        chk("t1_idle", 64'(idle), 64'(1));

        // chaining
        push(10'd10, 10'd10, 10'd20, 10'd15, 1'b0);
        push(10'd999, 10'd999, 10'd5, 10'd30, 1'b1);
        end_push();
        wait_idle("t2_idle", 200);
        chk("t2_lines_done", 64'(lines_done), 64'(3));

        // back-to-back with zero bubble
        stub_len = 3;
        push(10'd1, 10'd2, 10'd3, 10'd4, 1'b0);
        push(10'd5, 10'd6, 10'd7, 10'd8, 1'b0);
        end_push();
        wait_busy("t6_busy_rise", 1'b1, 50);
        wait_busy("t6_busy_fall", 1'b0, 50);
        @(negedge pclk);
        chk("t6_b2b_go", 64'(ld_go), 64'(1));
        chk("t6_no_idle", 64'(idle), 64'(0));
        wait_idle("t6_idle", 200);
        chk("t6_lines_done", 64'(lines_done), 64'(5));

        // zero-length segment
        stub_len = 1;
        push(10'd7, 10'd7, 10'd7, 10'd7, 1'b0);
        end_push();
        wait_idle("zl_idle", 100);
        chk("zl_lines_done", 64'(lines_done), 64'(6));

        // randomized traffic
        rand_len = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) begin
                end_push();
                repeat ($urandom_range(0, 2)) @(negedge pclk);
            end
        end
        end_push();
        wait_idle("rnd_idle", 3000);
        rand_len = 1'b0;
        chk("rnd_lines_done", 64'(lines_done), 64'(exp_done));
        chk("rnd_lines_total", 64'(lines_done), 64'(46));
        chk("rnd_err", 64'(err_timeout), 64'(0));

        // FIFO full, long draws
        stub_len = 100;
        for (int i = 0; i < 5; i++) begin
            push(10'(100 + i), 10'(200 + i), 10'(300 + i), 10'(400 + i), 1'b0);
        end
        @(negedge pclk);
        chk("t3_full_ready", 64'(cmd_ready), 64'(0));
        push(10'd600, 10'd601, 10'd602, 10'd603, 1'b0);
        end_push();
        wait_idle("t3_idle", 1500);
        chk("t3_lines_done", 64'(lines_done), 64'(52));
        chk("t3_err_long_draw", 64'(err_timeout), 64'(1));

        do_reset();
        @(negedge pclk);
        chk("rst2_err", 64'(err_timeout), 64'(0));
        chk("rst2_lines_done", 64'(lines_done), 64'(0));

        // watchdog in ARM
        stub_len = 2;
        skip_gos = 1;
        push(10'd100, 10'd100, 10'd200, 10'd200, 1'b0);
        push(10'd1, 10'd1, 10'd2, 10'd2, 1'b1);
        end_push();
        begin
            int n = 0;
            while (!ld_go && n < 20) begin
                @(negedge pclk);
                n++;
            end
            if (!ld_go) bound_fail("t4_first_go");
        end
        repeat (16) @(negedge pclk);
        chk("t4_err_before", 64'(err_timeout), 64'(0));
        @(negedge pclk);
        chk("t4_err_after", 64'(err_timeout), 64'(1));
        chk("t4_dropped", 64'(lines_done), 64'(0));
        wait_idle("t4_idle", 200);
        chk("t4_lines_done", 64'(lines_done), 64'(1));

        // reset while the drawer is busy
        stub_len = 30;
        push(10'd50, 10'd60, 10'd70, 10'd80, 1'b0);
        end_push();
        wait_busy("t5_busy_rise", 1'b1, 50);
        repeat (3) @(negedge pclk);
        do_reset();
        @(negedge pclk);
        chk("t5_go_low", 64'(ld_go), 64'(0));
        chk("t5_lines_done", 64'(lines_done), 64'(0));
        chk("t5_coords", 64'({ld_stax, ld_stay, ld_endx, ld_endy}), 64'(0));
        chk("t5_not_idle", 64'(idle), 64'(0));
        stub_len = 2;
        push(10'd0, 10'd0, 10'd9, 10'd9, 1'b1);
        end_push();
        wait_busy("t5_busy_fall", 1'b0, 60);
        chk("t5_go_hold", 64'(ld_go), 64'(0));
        @(negedge pclk);
        chk("t5_go_after_busy", 64'(ld_go), 64'(1));
        wait_idle("t5_idle", 200);
        chk("t5_lines_new", 64'(lines_done), 64'(1));
        chk("t5_lines_model", 64'(lines_done), 64'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
